// File: rtl/camera_pkg.sv
// ---------------------------------------------------------------------------
// camera_pkg
// Shared types and constants for the camera capture front end.
//   cap_state_e : capture FSM states
//   pix_fmt_e   : camera pixel format selector (RGB565 / RGB444)
//   R_W/G_W/B_W : RGB332 field widths
//   RED_*/BLUE_*: colour classifier thresholds (used when the design is
//                 built with CAMERA_COLOR_STATS_EN defined)
//   to_rgb332   : truncating two-byte pixel to RGB332 conversion
// ---------------------------------------------------------------------------
package camera_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_FRAME = 2'd0,
        ST_LINE_WAIT  = 2'd1,
        ST_BYTE0      = 2'd2,
        ST_BYTE1      = 2'd3
    } cap_state_e;

    typedef enum logic {
        FMT_RGB565 = 1'b0,
        FMT_RGB444 = 1'b1
    } pix_fmt_e;

    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int PIX_W = R_W + G_W + B_W;

    localparam logic [R_W-1:0] RED_R_MIN  = 3'd5;
    localparam logic [B_W-1:0] RED_B_MAX  = 2'd1;
    localparam logic [B_W-1:0] BLUE_B_MIN = 2'd2;
    localparam logic [R_W-1:0] BLUE_R_MAX = 3'd2;

    // Pixel word is {byte0, byte1}; conversion keeps the top bits of each
    // colour field (plain truncation).
    function automatic logic [PIX_W-1:0] to_rgb332(input pix_fmt_e fmt,
                                                   input logic [7:0] b0,
                                                   input logic [7:0] b1);
        logic [15:0]      p;
        logic [PIX_W-1:0] c;
        p = {b0, b1};
        if (fmt == FMT_RGB565)
            c = {p[15:13], p[10:8], p[4:3]};
        else
            c = {p[11:9], p[7:5], p[3:2]};
        return c;
    endfunction

    function automatic logic is_red(input logic [PIX_W-1:0] c);
        return (c[PIX_W-1 -: R_W] >= RED_R_MIN) && (c[B_W-1:0] <= RED_B_MAX);
    endfunction

    function automatic logic is_blue(input logic [PIX_W-1:0] c);
        return (c[B_W-1:0] >= BLUE_B_MIN) && (c[PIX_W-1 -: R_W] <= BLUE_R_MAX);
    endfunction

endpackage

// File: rtl/cam_sync.sv
// ---------------------------------------------------------------------------
// cam_sync
// Brings the asynchronous camera pins into the system clock domain.
// PCLK/HREF/VSYNC and DATA share one SYNC_STAGES-deep chain so they stay
// aligned; edge pulses, the HREF level and DATA are registered once more so
// every output refers to the same sample.
// Ports:
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_pclk/i_href/i_vsync camera timing pins (asynchronous)
//   i_data[7:0]           camera data bus (asynchronous)
//   o_pclk_rise           PCLK rising edge pulse
//   o_href_rise/_fall     HREF edge pulses, o_href synced HREF level
//   o_vsync_rise/_fall    VSYNC edge pulses
//   o_data[7:0]           DATA aligned with the pulses above
// ---------------------------------------------------------------------------
module cam_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pclk,
    input  logic       i_href,
    input  logic       i_vsync,
    input  logic [7:0] i_data,
    output logic       o_pclk_rise,
    output logic       o_href_rise,
    output logic       o_href_fall,
    output logic       o_href,
    output logic       o_vsync_rise,
    output logic       o_vsync_fall,
    output logic [7:0] o_data
);
    localparam int SW = 11;   // {vsync, href, pclk, data[7:0]}

    logic [SW-1:0] r_sync [SYNC_STAGES];
    logic [SW-1:0] w_last;
    logic [2:0]    r_prev;    // {vsync, href, pclk} of the previous sample

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge i_clk) begin
                    if (i_reset) r_sync[gi] <= '0;
                    else         r_sync[gi] <= {i_vsync, i_href, i_pclk, i_data};
                end
            end else begin : g_next
                always_ff @(posedge i_clk) begin
                    if (i_reset) r_sync[gi] <= '0;
                    else         r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_last = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev       <= '0;
            o_pclk_rise  <= 1'b0;
            o_href_rise  <= 1'b0;
            o_href_fall  <= 1'b0;
            o_href       <= 1'b0;
            o_vsync_rise <= 1'b0;
            o_vsync_fall <= 1'b0;
            o_data       <= '0;
        end else begin
            r_prev       <= w_last[10:8];
            o_pclk_rise  <=  w_last[8] & ~r_prev[0];
            o_href_rise  <=  w_last[9] & ~r_prev[1];
            o_href_fall  <= ~w_last[9] &  r_prev[1];
            o_href       <=  w_last[9];
            o_vsync_rise <=  w_last[10] & ~r_prev[2];
            o_vsync_fall <= ~w_last[10] &  r_prev[2];
            o_data       <=  w_last[7:0];
        end
    end

endmodule

// File: rtl/camera_capture.sv
// ---------------------------------------------------------------------------
// camera_capture
// OV7670-style capture front end: assembles two-byte pixels (RGB565 or
// RGB444, chosen per frame) from the synchronised camera bus and emits RGB332
// pixels with frame-buffer coordinates and a one-cycle write strobe.
// Optional feature macro: CAMERA_COLOR_STATS_EN adds a red/blue pixel
// classifier whose per-frame counts appear on o_red_cnt/o_blue_cnt; without
// it those ports are tied to zero.
// Ports:
//   i_clk, i_reset          system clock (>= 4x PCLK), sync active-high reset
//   i_data, i_pclk, i_href, i_vsync  camera pins (asynchronous)
//   i_fmt                   0 = RGB565, 1 = RGB444, sampled at frame start
//   o_pixel_color           RGB332 pixel
//   o_x, o_y                coordinates of o_pixel_color
//   o_w_en                  one-cycle write strobe
//   o_frame_done            one-cycle end-of-frame pulse
//   o_red_cnt, o_blue_cnt   previous frame's colour counts
// ---------------------------------------------------------------------------
module camera_capture
    import camera_pkg::*;
#(
    parameter int IMG_W       = 176,
    parameter int IMG_H       = 144,
    parameter int SYNC_STAGES = 2,
    parameter int XW          = $clog2(IMG_W),
    parameter int YW          = $clog2(IMG_H),
    parameter int CNT_W       = $clog2(IMG_W*IMG_H+1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [7:0]       i_data,
    input  logic             i_pclk,
    input  logic             i_href,
    input  logic             i_vsync,
    input  logic             i_fmt,
    output logic [7:0]       o_pixel_color,
    output logic [XW-1:0]    o_x,
    output logic [YW-1:0]    o_y,
    output logic             o_w_en,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_red_cnt,
    output logic [CNT_W-1:0] o_blue_cnt
);
    // Internal counters need one extra code so they can saturate at IMG_W/IMG_H.
    localparam int CXW = $clog2(IMG_W+1);
    localparam int CYW = $clog2(IMG_H+1);
    localparam logic [CXW-1:0] COL_LIM = CXW'(IMG_W);
    localparam logic [CYW-1:0] ROW_LIM = CYW'(IMG_H);

    logic       w_pclk_rise, w_href_rise, w_href_fall, w_href;
    logic       w_vsync_rise, w_vsync_fall;
    logic [7:0] w_data;

    cam_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pclk       (i_pclk),
        .i_href       (i_href),
        .i_vsync      (i_vsync),
        .i_data       (i_data),
        .o_pclk_rise  (w_pclk_rise),
        .o_href_rise  (w_href_rise),
        .o_href_fall  (w_href_fall),
        .o_href       (w_href),
        .o_vsync_rise (w_vsync_rise),
        .o_vsync_fall (w_vsync_fall),
        .o_data       (w_data)
    );

    cap_state_e     r_state;
    pix_fmt_e       r_fmt;
    logic [7:0]     r_temp;
    logic [CXW-1:0] r_col;
    logic [CYW-1:0] r_row;

    logic       w_byte, w_pixel, w_write, w_frame_end, w_line_used;
    logic [7:0] w_rgb;

    always_comb begin
        // A PCLK edge seen together with the HREF fall still belongs to the line.
        w_byte      = w_pclk_rise && (w_href || w_href_fall);
        w_frame_end = (r_state != ST_WAIT_FRAME) && w_vsync_rise;
        w_pixel     = (r_state == ST_BYTE1) && w_byte && !w_vsync_rise;
        w_write     = w_pixel && (r_col < COL_LIM) && (r_row < ROW_LIM);
        w_rgb       = to_rgb332(r_fmt, r_temp, w_data);
        w_line_used = (r_col != '0) || w_pixel;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_WAIT_FRAME;
            r_fmt         <= FMT_RGB565;
            r_temp        <= '0;
            r_col         <= '0;
            r_row         <= '0;
            o_pixel_color <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_w_en        <= 1'b0;
            o_frame_done  <= 1'b0;
        end else begin
            o_w_en       <= w_write;
            o_frame_done <= w_frame_end;
            case (r_state)
                ST_WAIT_FRAME: begin
                    if (w_vsync_fall) begin
                        r_fmt   <= pix_fmt_e'(i_fmt);
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= ST_LINE_WAIT;
                    end
                end
                ST_LINE_WAIT: begin
                    if (w_frame_end) begin
                        r_state <= ST_WAIT_FRAME;
                    end else if (w_href_rise) begin
                        r_col   <= '0;
                        r_state <= ST_BYTE0;
                    end
                end
                default: begin
                    if (w_frame_end) begin
                        r_state <= ST_WAIT_FRAME;
                    end else begin
                        if (w_write) begin
                            o_pixel_color <= w_rgb;
                            o_x           <= r_col[XW-1:0];
                            o_y           <= r_row[YW-1:0];
                        end
                        if (w_pixel && (r_col < COL_LIM))
                            r_col <= r_col + CXW'(1);
                        if ((r_state == ST_BYTE0) && w_byte)
                            r_temp <= w_data;
                        // Line end wins over byte toggling; a held odd byte is dropped.
                        if (w_href_fall) begin
                            r_state <= ST_LINE_WAIT;
                            if (w_line_used && (r_row < ROW_LIM))
                                r_row <= r_row + CYW'(1);
                        end else if (w_byte) begin
                            r_state <= (r_state == ST_BYTE0) ? ST_BYTE1 : ST_BYTE0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef CAMERA_COLOR_STATS_EN
    logic [CNT_W-1:0] r_red_run, r_blue_run, r_red_cnt, r_blue_cnt;

    // Running counts are published and cleared on the same edge that
    // raises o_frame_done.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_red_run  <= '0;
            r_blue_run <= '0;
            r_red_cnt  <= '0;
            r_blue_cnt <= '0;
        end else if (w_frame_end) begin
            r_red_cnt  <= r_red_run;
            r_blue_cnt <= r_blue_run;
            r_red_run  <= '0;
            r_blue_run <= '0;
        end else if (w_write) begin
            if (is_red(w_rgb))  r_red_run  <= r_red_run + CNT_W'(1);
            if (is_blue(w_rgb)) r_blue_run <= r_blue_run + CNT_W'(1);
        end
    end

    assign o_red_cnt  = r_red_cnt;
    assign o_blue_cnt = r_blue_cnt;
`else
    assign o_red_cnt  = '0;
    assign o_blue_cnt = '0;
`endif

endmodule
